game_draw_engine: RTL and testbench

- Responder side of the game view control handshake.
- Accepts one of four level draw requests (background, gold, stone, hook) from the view controller.
- Rasterises the matching solid rectangle into the VGA frame-buffer write port, one pixel per clock.
- Returns a one-cycle done pulse per request. Sits between the view controller and the VGA adapter.

---
 rtl/game_view_pkg.sv | 28 ++
 rtl/game_draw_engine_if.sv | 39 +++
 rtl/game_draw_engine_rect_scanner.sv | 61 ++++++
 rtl/game_draw_engine.sv | 212 +++++++++++++++++++++
 tb/tb_game_draw_engine.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/game_view_pkg.sv
// Shared constants and encodings for the game view controller and the draw engine.
package game_view_pkg;

    localparam int GV_SCREEN_W  = 160;
    localparam int GV_SCREEN_H  = 120;
    localparam int GV_OBJ_SIZE  = 8;
    localparam int GV_HOOK_SIZE = 4;

    localparam logic [2:0] GV_BG_COLOUR    = 3'b011;
    localparam logic [2:0] GV_GOLD_COLOUR  = 3'b110;
    localparam logic [2:0] GV_STONE_COLOUR = 3'b111;
    localparam logic [2:0] GV_HOOK_COLOUR  = 3'b100;

    typedef enum logic [1:0] {
        DRAW_BG    = 2'd0,
        DRAW_GOLD  = 2'd1,
        DRAW_STONE = 2'd2,
        DRAW_HOOK  = 2'd3
    } draw_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_PLOT  = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_e;

endpackage

// File: rtl/game_draw_engine_if.sv
// Request/done handshake between view controller and draw engine, plus the frame-buffer write port.
interface game_draw_engine_if;

    logic       enable_draw_background;
    logic       enable_draw_gold;
    logic       enable_draw_stone;
    logic       enable_draw_hook;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [7:0] hook_x;
    logic [6:0] hook_y;

    logic       draw_background_done;
    logic       draw_gold_done;
    logic       draw_stone_done;
    logic       draw_hook_done;

    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    // View controller side
    modport master (
        output enable_draw_background, enable_draw_gold, enable_draw_stone, enable_draw_hook,
        output obj_x, obj_y, hook_x, hook_y,
        input  draw_background_done, draw_gold_done, draw_stone_done, draw_hook_done,
        input  plot, vga_x, vga_y, colour
    );

    // Draw engine side
    modport slave (
        input  enable_draw_background, enable_draw_gold, enable_draw_stone, enable_draw_hook,
        input  obj_x, obj_y, hook_x, hook_y,
        output draw_background_done, draw_gold_done, draw_stone_done, draw_hook_done,
        output plot, vga_x, vga_y, colour
    );

endinterface

// File: rtl/game_draw_engine_rect_scanner.sv
// Nested column/row counter walking a width x height rectangle in raster order, one cell per clock.
module rect_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] width,
    input  logic [7:0] height,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       valid,
    output logic       last
);

    logic       running_q, running_d;
    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic       col_end;
    logic       row_end;

    always_comb begin
        col_end   = ({1'b0, col_q} == (width - 9'd1));
        row_end   = ({1'b0, row_q} == (height - 8'd1));
        running_d = running_q;
        col_d     = col_q;
        row_d     = row_q;
        if (start) begin
            running_d = 1'b1;
            col_d     = '0;
            row_d     = '0;
        end else if (running_q) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    running_d = 1'b0;
                end else begin
                    row_d = row_q + 7'd1;
                end
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            running_q <= running_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    assign col   = col_q;
    assign row   = row_q;
    assign valid = running_q;
    assign last  = running_q & col_end & row_end;

endmodule

// File: rtl/game_draw_engine.sv
// Draw engine: takes one level draw request at a time, rasterises the matching solid rectangle
// into the frame-buffer write port and pulses the matching done output once.
module game_draw_engine
    import game_view_pkg::*;
#(
    parameter int         SCREEN_W     = GV_SCREEN_W,
    parameter int         SCREEN_H     = GV_SCREEN_H,
    parameter int         OBJ_SIZE     = GV_OBJ_SIZE,
    parameter int         HOOK_SIZE    = GV_HOOK_SIZE,
    parameter logic [2:0] BG_COLOUR    = GV_BG_COLOUR,
    parameter logic [2:0] GOLD_COLOUR  = GV_GOLD_COLOUR,
    parameter logic [2:0] STONE_COLOUR = GV_STONE_COLOUR,
    parameter logic [2:0] HOOK_COLOUR  = GV_HOOK_COLOUR
) (
    input  logic              clk,
    input  logic              reset,
    game_draw_engine_if.slave bus
);

    localparam logic [8:0] SCR_W9  = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H8  = 8'(SCREEN_H);
    localparam logic [8:0] OBJ_W9  = 9'(OBJ_SIZE);
    localparam logic [7:0] OBJ_H8  = 8'(OBJ_SIZE);
    localparam logic [8:0] HOOK_W9 = 9'(HOOK_SIZE);
    localparam logic [7:0] HOOK_H8 = 8'(HOOK_SIZE);

    draw_state_e state_q, state_d;
    draw_type_e  type_q, type_d;
    logic [7:0]  org_x_q, org_x_d;
    logic [6:0]  org_y_q, org_y_d;
    logic [8:0]  size_w_q, size_w_d;
    logic [7:0]  size_h_q, size_h_d;
    logic [2:0]  fill_q, fill_d;

    logic        pix_last_q, pix_last_d;
    logic        plot_q, plot_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  colour_q, colour_d;
    logic [3:0]  done_q, done_d;

    logic        req_any;
    draw_type_e  req_type;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [8:0]  sel_w;
    logic [7:0]  sel_h;
    logic [2:0]  sel_fill;

    logic        scan_start;
    logic [7:0]  scan_col;
    logic [6:0]  scan_row;
    logic        scan_valid;
    logic        scan_last;
    logic [8:0]  x_sum;
    logic [7:0]  y_sum;

    rect_scanner u_scanner (
        .clk    (clk),
        .reset  (reset),
        .start  (scan_start),
        .width  (size_w_q),
        .height (size_h_q),
        .col    (scan_col),
        .row    (scan_row),
        .valid  (scan_valid),
        .last   (scan_last)
    );

    // Fixed priority between simultaneous requests: background > gold > stone > hook
    always_comb begin
        req_any = bus.enable_draw_background | bus.enable_draw_gold |
                  bus.enable_draw_stone | bus.enable_draw_hook;
        if (bus.enable_draw_background) begin
            req_type = DRAW_BG;
        end else if (bus.enable_draw_gold) begin
            req_type = DRAW_GOLD;
        end else if (bus.enable_draw_stone) begin
            req_type = DRAW_STONE;
        end else begin
            req_type = DRAW_HOOK;
        end

        sel_x    = bus.hook_x;
        sel_y    = bus.hook_y;
        sel_w    = HOOK_W9;
        sel_h    = HOOK_H8;
        sel_fill = HOOK_COLOUR;
        case (req_type)
            DRAW_BG: begin
                sel_x    = '0;
                sel_y    = '0;
                sel_w    = SCR_W9;
                sel_h    = SCR_H8;
                sel_fill = BG_COLOUR;
            end
            DRAW_GOLD: begin
                sel_x    = bus.obj_x;
                sel_y    = bus.obj_y;
                sel_w    = OBJ_W9;
                sel_h    = OBJ_H8;
                sel_fill = GOLD_COLOUR;
            end
            DRAW_STONE: begin
                sel_x    = bus.obj_x;
                sel_y    = bus.obj_y;
                sel_w    = OBJ_W9;
                sel_h    = OBJ_H8;
                sel_fill = STONE_COLOUR;
            end
            default: ;
        endcase
    end

    // Request operands are captured on the IDLE->LATCH edge so the scanner can already step
    // through LATCH; the registered pixel outputs then line up with the PLOT state exactly.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        size_w_d   = size_w_q;
        size_h_d   = size_h_q;
        fill_d     = fill_q;
        scan_start = 1'b0;
        done_d     = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d    = ST_LATCH;
                    scan_start = 1'b1;
                    type_d     = req_type;
                    org_x_d    = sel_x;
                    org_y_d    = sel_y;
                    size_w_d   = sel_w;
                    size_h_d   = sel_h;
                    fill_d     = sel_fill;
                end
            end
            ST_LATCH: begin
                state_d = ST_PLOT;
            end
            ST_PLOT: begin
                if (pix_last_q) begin
                    state_d = ST_DONE;
                    done_d  = 4'b0001 << type_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel stage: sums are one bit wider than the screen coordinates so clipping never wraps
    always_comb begin
        x_sum      = {1'b0, org_x_q} + {1'b0, scan_col};
        y_sum      = {1'b0, org_y_q} + {1'b0, scan_row};
        pix_last_d = scan_last;
        plot_d     = scan_valid && (x_sum < SCR_W9) && (y_sum < SCR_H8);
        vga_x_d    = vga_x_q;
        vga_y_d    = vga_y_q;
        colour_d   = colour_q;
        if (scan_valid) begin
            vga_x_d  = x_sum[7:0];
            vga_y_d  = y_sum[6:0];
            colour_d = fill_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            type_q     <= DRAW_BG;
            org_x_q    <= '0;
            org_y_q    <= '0;
            size_w_q   <= '0;
            size_h_q   <= '0;
            fill_q     <= '0;
            pix_last_q <= 1'b0;
            plot_q     <= 1'b0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            colour_q   <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            size_w_q   <= size_w_d;
            size_h_q   <= size_h_d;
            fill_q     <= fill_d;
            pix_last_q <= pix_last_d;
            plot_q     <= plot_d;
            vga_x_q    <= vga_x_d;
            vga_y_q    <= vga_y_d;
            colour_q   <= colour_d;
            done_q     <= done_d;
        end
    end

    assign bus.plot                 = plot_q;
    assign bus.vga_x                = vga_x_q;
    assign bus.vga_y                = vga_y_q;
    assign bus.colour               = colour_q;
    assign bus.draw_background_done = done_q[DRAW_BG];
    assign bus.draw_gold_done       = done_q[DRAW_GOLD];
    assign bus.draw_stone_done      = done_q[DRAW_STONE];
    assign bus.draw_hook_done       = done_q[DRAW_HOOK];

endmodule

// File: tb/tb_game_draw_engine.sv
// Directed bench for game_draw_engine: a table of single draws plus priority, input-change and reset sequences.
module tb_game_draw_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    game_draw_engine_if bus ();

    game_draw_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         kind;   // 0 bg, 1 gold, 2 stone, 3 hook
        logic [7:0] ox;
        logic [6:0] oy;
        bit         chg;    // drop enable and move origin inputs mid-draw
        int         plots;
        int         dk;     // cycle of done pulse after request sampled
        logic [2:0] col;
        int         lx;
        int         ly;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dones();
        return {bus.draw_hook_done, bus.draw_stone_done, bus.draw_gold_done, bus.draw_background_done};
    endfunction

    task automatic set_req(input int kind, input logic v);
        case (kind)
            0:       bus.enable_draw_background = v;
            1:       bus.enable_draw_gold = v;
            2:       bus.enable_draw_stone = v;
            default: bus.enable_draw_hook = v;
        endcase
    endtask

    // Issue one request at a negedge; sample every following negedge (k = cycles after sampling)
    task automatic run_vec(input vec_t v, input int idx);
        int w, h, n, plots, bad_pix, done_k, done_cnt, wrong_done, ex, ey, p, lx, ly;
        logic exp_plot;
        logic [3:0] d;
        w = (v.kind == 0) ? 160 : (v.kind == 3) ? 4 : 8;
        h = (v.kind == 0) ? 120 : (v.kind == 3) ? 4 : 8;
        n = w * h;
        plots = 0; bad_pix = 0; done_k = -1; done_cnt = 0; wrong_done = 0;
        lx = -1; ly = -1; ex = 0; ey = 0;
        if (v.kind == 3) begin
            bus.hook_x = v.ox; bus.hook_y = v.oy;
        end else begin
            bus.obj_x = v.ox; bus.obj_y = v.oy;
        end
        set_req(v.kind, 1'b1);
        for (int k = 1; k <= v.dk + 2; k++) begin
            @(negedge clk);
            if (v.chg && k == 5) begin
                set_req(v.kind, 1'b0);
                bus.hook_x = 8'd100; bus.hook_y = 7'd5;
                bus.obj_x  = 8'd100; bus.obj_y  = 7'd5;
            end
            if (k >= 2 && k <= n + 1) begin
                p  = k - 2;
                ex = int'(v.ox) + (p % w);
                ey = int'(v.oy) + (p / w);
                exp_plot = (ex < 160) && (ey < 120);
            end else begin
                exp_plot = 1'b0;
            end
            if (bus.plot !== exp_plot) bad_pix++;
            if (bus.plot === 1'b1) begin
                plots++;
                lx = int'(bus.vga_x);
                ly = int'(bus.vga_y);
                if (exp_plot && (bus.vga_x !== ex[7:0] || bus.vga_y !== ey[6:0] || bus.colour !== v.col))
                    bad_pix++;
            end
            d = dones();
            if (d[v.kind] === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                set_req(v.kind, 1'b0);
            end
            if ((d & ~(4'b0001 << v.kind)) != 4'b0000) wrong_done++;
        end
        check($sformatf("vec%0d_plots", idx), plots, v.plots);
        check($sformatf("vec%0d_pixels_bad", idx), bad_pix, 0);
        check($sformatf("vec%0d_done_cycle", idx), done_k, v.dk);
        check($sformatf("vec%0d_done_count", idx), done_cnt, 1);
        check($sformatf("vec%0d_wrong_done", idx), wrong_done, 0);
        check($sformatf("vec%0d_last_x", idx), lx, v.lx);
        check($sformatf("vec%0d_last_y", idx), ly, v.ly);
    endtask

    initial begin
        int gdk, hdk, multi, gp, hp, nd, quiet;
        logic [3:0] d;

        vecs[0] = '{kind: 1, ox: 8'd10,  oy: 7'd20,  chg: 1'b0, plots: 64,    dk: 66,    col: 3'b110, lx: 17,  ly: 27};
        vecs[1] = '{kind: 2, ox: 8'd156, oy: 7'd116, chg: 1'b0, plots: 16,    dk: 66,    col: 3'b111, lx: 159, ly: 119};
        vecs[2] = '{kind: 3, ox: 8'd40,  oy: 7'd30,  chg: 1'b1, plots: 16,    dk: 18,    col: 3'b100, lx: 43,  ly: 33};
        vecs[3] = '{kind: 0, ox: 8'd0,   oy: 7'd0,   chg: 1'b0, plots: 19200, dk: 19202, col: 3'b011, lx: 159, ly: 119};
        vecs[4] = '{kind: 1, ox: 8'd158, oy: 7'd50,  chg: 1'b0, plots: 16,    dk: 66,    col: 3'b110, lx: 159, ly: 57};
        vecs[5] = '{kind: 3, ox: 8'd159, oy: 7'd119, chg: 1'b0, plots: 1,     dk: 18,    col: 3'b100, lx: 159, ly: 119};

        bus.enable_draw_background = 1'b0;
        bus.enable_draw_gold = 1'b0;
        bus.enable_draw_stone = 1'b0;
        bus.enable_draw_hook = 1'b0;
        bus.obj_x = '0; bus.obj_y = '0; bus.hook_x = '0; bus.hook_y = '0;

        repeat (3) @(negedge clk);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_vga_x", int'(bus.vga_x), 0);
        check("rst_vga_y", int'(bus.vga_y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_dones", int'(dones()), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Gold and hook together: gold first, hook follows while its enable stays high
        bus.obj_x = 8'd10; bus.obj_y = 7'd20; bus.hook_x = 8'd60; bus.hook_y = 7'd40;
        bus.enable_draw_gold = 1'b1;
        bus.enable_draw_hook = 1'b1;
        gdk = -1; hdk = -1; multi = 0; gp = 0; hp = 0; nd = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            d = dones();
            if ((d[0] + d[1] + d[2] + d[3]) > 1) multi++;
            nd += d[0] + d[1] + d[2] + d[3];
            if (d[1] === 1'b1) begin
                if (gdk < 0) gdk = k;
                bus.enable_draw_gold = 1'b0;
            end
            if (d[3] === 1'b1) begin
                if (hdk < 0) hdk = k;
                bus.enable_draw_hook = 1'b0;
            end
            if (bus.plot === 1'b1) begin
                if (bus.colour === 3'b110) gp++;
                else if (bus.colour === 3'b100) hp++;
            end
        end
        check("prio_gold_done", gdk, 66);
        check("prio_hook_done", hdk, 85);
        check("prio_multi_done", multi, 0);
        check("prio_done_total", nd, 2);
        check("prio_gold_plots", gp, 64);
        check("prio_hook_plots", hp, 16);

        // Reset in the middle of a gold draw
        bus.obj_x = 8'd10; bus.obj_y = 7'd20;
        bus.enable_draw_gold = 1'b1;
        for (int k = 1; k <= 32; k++) @(negedge clk);
        check("mid_plot_active", int'(bus.plot), 1);
        check("mid_pixel30_x", int'(bus.vga_x), 16);
        check("mid_pixel30_y", int'(bus.vga_y), 23);
        reset = 1'b1;
        #1;
        check("abort_plot", int'(bus.plot), 0);
        check("abort_vga_x", int'(bus.vga_x), 0);
        check("abort_dones", int'(dones()), 0);
        @(negedge clk);
        bus.enable_draw_gold = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.plot !== 1'b0 || dones() !== 4'b0000) quiet++;
        end
        check("abort_quiet", quiet, 0);
        run_vec(vecs[0], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
